// File: rtl/apdtimer_pkg.sv
// Shared definitions for the APD time-tagger acquisition path.
//   APD_DATA_W     : width of one timer record
//   APD_NUM_CH     : number of detector channels on the tagger
//   apdseq_state_t : acquisition sequencer state encoding
package apdtimer_pkg;

    localparam int unsigned APD_DATA_W = 41;
    localparam int unsigned APD_NUM_CH = 4;

    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StClear = 2'd1,
        StRun   = 2'd2,
        StDrain = 2'd3
    } apdseq_state_t;

endpackage

// File: rtl/apdseq_fifo2.sv
// Two-entry FIFO built as a head/tail register pair, so the head is always the
// output word and needs no read mux.
// Ports:
//   clk, reset_n : clock, synchronous active-low reset
//   push         : write push_data (caller guarantees room, or a same-cycle pop)
//   push_data    : word to write
//   pop          : retire the head word (ignored when empty)
//   count        : occupancy, 0..2
//   head         : oldest stored word
module apdseq_fifo2
    import apdtimer_pkg::*;
#(
    parameter int unsigned DATA_W = APD_DATA_W
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              push,
    input  logic [DATA_W-1:0] push_data,
    input  logic              pop,
    output logic [1:0]        count,
    output logic [DATA_W-1:0] head
);

    logic [1:0]        count_q, count_d;
    logic [DATA_W-1:0] head_q, head_d;
    logic [DATA_W-1:0] tail_q, tail_d;

    always_comb begin
        count_d = count_q;
        head_d  = head_q;
        tail_d  = tail_q;
        case (count_q)
            2'd0: begin
                if (push) begin
                    head_d  = push_data;
                    count_d = 2'd1;
                end
            end
            2'd1: begin
                if (push && pop) begin
                    head_d = push_data;
                end else if (push) begin
                    tail_d  = push_data;
                    count_d = 2'd2;
                end else if (pop) begin
                    count_d = 2'd0;
                end
            end
            2'd2: begin
                if (pop) begin
                    head_d = tail_q;
                    if (push) begin
                        tail_d = push_data;
                    end else begin
                        count_d = 2'd1;
                    end
                end
            end
            default: count_d = 2'd0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            count_q <= 2'd0;
            head_q  <= '0;
            tail_q  <= '0;
        end else begin
            count_q <= count_d;
            head_q  <= head_d;
            tail_q  <= tail_d;
        end
    end

    assign count = count_q;
    assign head  = head_q;

endmodule

// File: rtl/apdtimer_seq.sv
// Acquisition sequencer for the four-channel APD time-tagger. Runs the timer
// through clear -> run -> drain, buffers timer records in a 2-entry FIFO toward
// the host stream, and reports busy/done/overflow status.
// Optional feature macro: APDSEQ_LOST_CNT_EN adds the saturating lost_count port.
// Ports:
//   clk, reset_n          : clock, synchronous active-low reset
//   start, stop           : run commands, sampled every cycle
//   run_length            : operate cycles per run (0 = unlimited), taken on CLEAR exit
//   timer_rdy, timer_data : record strobe and payload from the timer
//   out_ready             : downstream ready
//   operate, reset_counter: timer controls
//   out_valid, out_data   : record stream toward the host FIFO
//   busy, done, overflow  : status; lost_count only with APDSEQ_LOST_CNT_EN
module apdtimer_seq
    import apdtimer_pkg::*;
#(
    parameter int unsigned DATA_W       = APD_DATA_W,
    parameter int unsigned RUN_W        = 32,
    parameter int unsigned CLEAR_CYCLES = 4,
    parameter int unsigned DRAIN_CYCLES = 8,
    parameter int unsigned LOST_W       = 16
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              start,
    input  logic              stop,
    input  logic [RUN_W-1:0]  run_length,
    input  logic              timer_rdy,
    input  logic [DATA_W-1:0] timer_data,
    input  logic              out_ready,
    output logic              operate,
    output logic              reset_counter,
    output logic              out_valid,
    output logic [DATA_W-1:0] out_data,
    output logic              busy,
    output logic              done,
    output logic              overflow
`ifdef APDSEQ_LOST_CNT_EN
    ,
    output logic [LOST_W-1:0] lost_count
`endif
);

    // One phase counter serves both CLEAR and DRAIN.
    localparam int unsigned CNT_MAX = (CLEAR_CYCLES > DRAIN_CYCLES) ? CLEAR_CYCLES : DRAIN_CYCLES;
    localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);
    localparam logic [CNT_W-1:0] CLEAR_LAST = CNT_W'(CLEAR_CYCLES - 1);
    localparam logic [CNT_W-1:0] DRAIN_LAST = CNT_W'(DRAIN_CYCLES - 1);

    apdseq_state_t     state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [RUN_W-1:0]  remaining_q, remaining_d;
    logic              operate_q, reset_counter_q, busy_q, done_q, overflow_q;
    logic              clear_status;

    logic [1:0]        fifo_count;
    logic [DATA_W-1:0] fifo_head;
    logic              rec_accept, fifo_pop, fifo_push, rec_drop;

    // Records are only taken while the timer may still be producing them.
    assign rec_accept = timer_rdy && ((state_q == StRun) || (state_q == StDrain));
    assign fifo_pop   = (fifo_count != 2'd0) && out_ready;
    assign fifo_push  = rec_accept && ((fifo_count != 2'd2) || fifo_pop);
    assign rec_drop   = rec_accept && !fifo_push;

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        remaining_d  = remaining_q;
        clear_status = 1'b0;
        case (state_q)
            StIdle: begin
                if (start && !stop) begin
                    state_d      = StClear;
                    cnt_d        = '0;
                    clear_status = 1'b1;
                end
            end
            StClear: begin
                if (stop) begin
                    state_d = StIdle;
                end else if (cnt_q == CLEAR_LAST) begin
                    state_d     = StRun;
                    remaining_d = run_length;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            StRun: begin
                if (remaining_q != '0) begin
                    remaining_d = remaining_q - 1'b1;
                end
                if (stop || (remaining_q == RUN_W'(1))) begin
                    state_d = StDrain;
                    cnt_d   = '0;
                end
            end
            StDrain: begin
                if (cnt_q != DRAIN_LAST) begin
                    cnt_d = cnt_q + 1'b1;
                // Leave only when nothing is buffered or arriving this cycle.
                end else if ((fifo_count == 2'd0) && !timer_rdy) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q         <= StIdle;
            cnt_q           <= '0;
            remaining_q     <= '0;
            operate_q       <= 1'b0;
            reset_counter_q <= 1'b0;
            busy_q          <= 1'b0;
            done_q          <= 1'b0;
            overflow_q      <= 1'b0;
        end else begin
            state_q         <= state_d;
            cnt_q           <= cnt_d;
            remaining_q     <= remaining_d;
            operate_q       <= (state_d == StRun);
            reset_counter_q <= (state_d == StClear);
            busy_q          <= (state_d != StIdle);
            done_q          <= (state_q != StIdle) && (state_d == StIdle);
            if (clear_status) begin
                overflow_q <= 1'b0;
            end else if (rec_drop) begin
                overflow_q <= 1'b1;
            end
        end
    end

`ifdef APDSEQ_LOST_CNT_EN
    logic [LOST_W-1:0] lost_q;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            lost_q <= '0;
        end else if (clear_status) begin
            lost_q <= '0;
        end else if (rec_drop && (lost_q != '1)) begin
            lost_q <= lost_q + 1'b1;
        end
    end

    assign lost_count = lost_q;
`endif

    apdseq_fifo2 #(
        .DATA_W (DATA_W)
    ) u_fifo (
        .clk       (clk),
        .reset_n   (reset_n),
        .push      (fifo_push),
        .push_data (timer_data),
        .pop       (fifo_pop),
        .count     (fifo_count),
        .head      (fifo_head)
    );

    assign operate       = operate_q;
    assign reset_counter = reset_counter_q;
    assign busy          = busy_q;
    assign done          = done_q;
    assign overflow      = overflow_q;
    assign out_valid     = (fifo_count != 2'd0);
    assign out_data      = fifo_head;

endmodule

// File: doc/apdtimer_seq.md
# apdtimer_seq

Acquisition sequencer for the four-channel APD time-tagger. It accepts start/stop commands and drives the timer's `operate` and `reset_counter` inputs through a clear, run and drain sequence, with an optional run-length limit. Timer records (`data_rdy`/`data`) pass through a 2-entry buffer onto a valid/ready stream toward the host FIFO. The block reports busy, done, overflow and lost-record status.

## Interface
Parameters:
- `DATA_W`, 41: timer record width.
- `RUN_W`, 32: run-length counter width.
- `CLEAR_CYCLES`, 4: cycles `reset_counter` is held high; must be ≥1.
- `DRAIN_CYCLES`, 8: post-run cycles still accepting records (click-latch pipeline flush); must be ≥1.
- `LOST_W`, 16: lost-record counter width.

Ports:
- `clk`  in  1  sole clock, rising edge.
- `reset_n`  in  1  reset; synchronous, active-low.
- `start`  in  1  start request, sampled each cycle.
- `stop`  in  1  stop request, sampled each cycle.
- `run_length`  in  RUN_W  operate cycles per run; 0 means unlimited. Sampled on the cycle leaving CLEAR.
- `timer_rdy`  in  1  timer `data_rdy`.
- `timer_data`  in  DATA_W  timer `data`.
- `out_ready`  in  1  downstream ready.
- `operate`  out  1  to timer and detector gating.
- `reset_counter`  out  1  to timer clear.
- `out_valid`  out  1  buffer non-empty.
- `out_data`  out  DATA_W  buffer head.
- `busy`  out  1  state ≠ IDLE.
- `done`  out  1  one-cycle pulse on entry to IDLE from any other state.
- `overflow`  out  1  sticky; set when a record is dropped.
- `lost_count`  out  LOST_W  dropped records, saturating (only with `APDSEQ_LOST_CNT_EN`).

## Operation
- **State machine** (states IDLE, CLEAR, RUN, DRAIN):
  - IDLE→CLEAR on `start` with `stop` low. `start` and `stop` together in IDLE: stay IDLE, no `done`.
  - CLEAR: `reset_counter`=1 for exactly CLEAR_CYCLES cycles, then go to RUN and load `remaining` from `run_length`.
  - `stop` during CLEAR: go to IDLE on the next edge, with a `done` pulse.
  - RUN: `operate`=1. When `remaining`≠0 it decrements every cycle.
  - RUN→DRAIN when `remaining` is 1, or when `stop` is sampled. `run_length`=0 never self-terminates.
  - DRAIN: `operate`=0 for DRAIN_CYCLES cycles. Then go to IDLE on the first cycle with the buffer empty.
  - `start` is ignored outside IDLE. `stop` is ignored in DRAIN and IDLE.
- **Status on start:** IDLE→CLEAR clears `overflow` and `lost_count`.
- **Record acceptance:** only in RUN and DRAIN. `timer_rdy` in IDLE or CLEAR is discarded and not counted.
- **Buffer:** 2-entry FIFO.
  - A push is accepted when occupancy <2, or when occupancy is 2 and a pop happens in the same cycle (`out_valid`&`out_ready`).
  - Otherwise the record is dropped: `overflow` is set and `lost_count` increments, saturating at all-ones.
  - Output order equals arrival order. `out_data` is stable while `out_valid`&!`out_ready`.
- **Reset values** (`reset_n` low at an edge): state IDLE and buffer flushed. `operate`, `reset_counter`, `out_valid`, `busy`, `done` and `overflow` are 0; `out_data` and `lost_count` are 0. Reset applied mid-run aborts without a `done` pulse.

## Timing
- `start` sampled at edge 0:
  - `reset_counter` high during cycles 1..CLEAR_CYCLES.
  - `operate` high during cycles CLEAR_CYCLES+1..CLEAR_CYCLES+`run_length`.
- `stop` sampled at edge t in RUN: `operate` low from cycle t+1.
- `timer_rdy` at edge t into an empty buffer: `out_valid`=1 from cycle t+1. Sustained throughput is 1 record/cycle while `out_ready` is held high.
- `done` is high for the single cycle in which the state first reads IDLE.
- All outputs are registered. No combinational path from inputs to outputs.

## Configuration
- `APDSEQ_LOST_CNT_EN` defined: `lost_count` port and saturating counter present.
- `APDSEQ_LOST_CNT_EN` undefined: the port is absent and only the sticky `overflow` reports drops.
- All other behaviour is identical in both builds.

## Structure
- Shared package `apdtimer_pkg` holds:
  - `APD_DATA_W`=41.
  - `APD_NUM_CH`=4.
  - the state enum typedef `apdseq_state_t`.
- Sub-module `apdseq_fifo2`: 2-entry FIFO with push/pop/occupancy. The sequencer top instantiates it.

## Test plan
- **Bounded run:** reset, then `start` with `run_length`=10, CLEAR_CYCLES=4 → `reset_counter` high cycles 1–4, `operate` high cycles 5–14, `done` at cycle 14+8+1 with the buffer empty.
- **Stop mid-run:** `run_length`=0, `stop` at cycle 20 → `operate` low from 21, DRAIN 8 cycles, `done` pulse, `busy` low.
- **Back-pressure:** `out_ready`=0, three `timer_rdy` pulses in RUN → the first two are held in order, the third is dropped, `overflow`=1, `lost_count`=1. A new `start` clears both.
- **Full throughput:** `out_ready`=1, `timer_rdy` every cycle for 16 cycles → 16 records out, in order, one cycle late, no drops.
- **Simultaneous / ignored commands:** `start`+`stop` in IDLE → no state change. `start` in RUN → ignored. `timer_rdy` in CLEAR → no output.
- **Reset mid-run:** `reset_n` low in RUN with 2 records buffered → next cycle all outputs at reset values and the buffer is empty.
